tdc_thermo_decoder: RTL



---
 rtl/tdc_dec_pkg.sv | 33 +++
 rtl/tdc_thermo_decoder_if.sv | 34 +++
 rtl/tdc_code_accum.sv | 54 +++++
 rtl/tdc_thermo_decoder.sv | 99 +++++++++
 4 files changed

// File: rtl/tdc_dec_pkg.sv
// Shared definitions for the TDC thermometer decoder: default chain length,
// derived widths, majority vote and thermometer-to-binary conversion.
package tdc_dec_pkg;

  localparam int unsigned NTdcDefault = 32;
  // Upper bound on chain length accepted by therm2bin; callers zero-extend.
  localparam int unsigned MaxTdc      = 256;

  function automatic int unsigned calc_code_w(input int unsigned n_tdc);
    return $clog2(n_tdc + 1);
  endfunction

  function automatic int unsigned calc_sum_w(input int unsigned n_tdc,
                                             input int unsigned navg_log2);
    return calc_code_w(n_tdc) + navg_log2;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Number of consecutive ones starting at bit 0 (index of the first zero).
  function automatic int unsigned therm2bin(input logic [MaxTdc-1:0] c);
    int unsigned cnt = 0;
    logic        run = 1'b1;
    for (int unsigned i = 0; i < MaxTdc; i++) begin
      if (run && c[i]) cnt++;
      else             run = 1'b0;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/tdc_thermo_decoder_if.sv
// Sample-in / code-and-sum-out bundle of the TDC thermometer decoder.
// master: the side feeding chain samples; slave: the decoder.
interface tdc_thermo_decoder_if
  import tdc_dec_pkg::*;
#(
  parameter int unsigned N_TDC     = NTdcDefault,
  parameter int unsigned NAVG_LOG2 = 2
);
  localparam int unsigned CodeW = calc_code_w(N_TDC);
  localparam int unsigned SumW  = calc_sum_w(N_TDC, NAVG_LOG2);

  logic [N_TDC-1:0] therm_in;
  logic             pr_in;
  logic             in_valid;
  logic             acc_clr;
  logic [CodeW-1:0] code_out;
  logic             code_valid;
  logic             ovf;
  logic             unf;
  logic             bubble_err;
  logic [SumW-1:0]  sum_out;
  logic             sum_valid;

  modport master (
    output therm_in, pr_in, in_valid, acc_clr,
    input  code_out, code_valid, ovf, unf, bubble_err, sum_out, sum_valid
  );

  modport slave (
    input  therm_in, pr_in, in_valid, acc_clr,
    output code_out, code_valid, ovf, unf, bubble_err, sum_out, sum_valid
  );

endinterface

// File: rtl/tdc_code_accum.sv
// Sums 2^NavgLog2 decoded codes and strobes the total out; a clear zeroes the
// running sum and count and takes priority over a coincident code.
module tdc_code_accum #(
  parameter int unsigned CodeW    = 6,
  parameter int unsigned NavgLog2 = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      code_valid_i,
  input  logic [CodeW-1:0]          code_i,
  input  logic                      clr_i,
  output logic [CodeW+NavgLog2-1:0] sum_o,
  output logic                      sum_valid_o
);
  localparam int unsigned SumW = CodeW + NavgLog2;

  logic [SumW-1:0]     sum_q;
  logic [NavgLog2-1:0] cnt_q;
  logic [SumW-1:0]     sum_out_q;
  logic                sum_valid_q;
  logic [SumW-1:0]     sum_next;

  assign sum_next = sum_q + SumW'(code_i);

  // Running sum, sample counter and registered sum strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      cnt_q       <= '0;
      sum_out_q   <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_valid_q <= 1'b0;
      if (clr_i) begin
        sum_q <= '0;
        cnt_q <= '0;
      end else if (code_valid_i) begin
        if (&cnt_q) begin
          sum_out_q   <= sum_next;
          sum_valid_q <= 1'b1;
          sum_q       <= '0;
          cnt_q       <= '0;
        end else begin
          sum_q <= sum_next;
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign sum_o       = sum_out_q;
  assign sum_valid_o = sum_valid_q;

endmodule

// File: rtl/tdc_thermo_decoder.sv
// TDC delay-chain receive decoder: polarity normalisation, optional majority-3
// bubble correction (enabled by defining TDC_BUBBLE_CORR_EN), thermometer to
// binary conversion with range/bubble flags, and code accumulation.
module tdc_thermo_decoder
  import tdc_dec_pkg::*;
#(
  parameter int unsigned N_TDC     = NTdcDefault,
  parameter int unsigned NAVG_LOG2 = 2
) (
  input logic               clk,
  input logic               rst,
  tdc_thermo_decoder_if.slave bus
);
  localparam int unsigned CodeW = calc_code_w(N_TDC);
  localparam int unsigned SumW  = calc_sum_w(N_TDC, NAVG_LOG2);

  logic [N_TDC-1:0] w_q;
  logic             v1_q;
  logic [N_TDC-1:0] c;
  logic [CodeW-1:0] code_d, code_q;
  logic             ovf_d, ovf_q;
  logic             unf_d, unf_q;
  logic             bub_d, bub_q;
  logic             code_valid_q;
  logic [SumW-1:0]  sum_out;
  logic             sum_valid;

  // Stage 1: capture the sample with pr_in=0 meaning the chain saw inverted polarity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) w_q <= bus.pr_in ? bus.therm_in : ~bus.therm_in;
    end
  end

`ifdef TDC_BUBBLE_CORR_EN
  // Pad with a 1 below the chain input and a 0 above the chain end.
  logic [N_TDC+1:0] w_pad;
  assign w_pad = {1'b0, w_q, 1'b1};
  for (genvar i = 0; i < N_TDC; i++) begin : g_maj
    assign c[i] = maj3(w_pad[i], w_pad[i+1], w_pad[i+2]);
  end
`else
  assign c = w_q;
`endif

  // Stage 2 decode: leading-ones count plus range and monotonicity flags.
  always_comb begin
    code_d = CodeW'(therm2bin(MaxTdc'(c)));
    ovf_d  = &c;
    unf_d  = ~|c;
    // A 1 directly above a 0 anywhere means the word is not a thermometer code.
    bub_d  = |(c[N_TDC-1:1] & ~c[N_TDC-2:0]);
  end

  // Stage 2 registers; decoded fields hold between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q       <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      bub_q        <= 1'b0;
      code_valid_q <= 1'b0;
    end else begin
      code_valid_q <= v1_q;
      if (v1_q) begin
        code_q <= code_d;
        ovf_q  <= ovf_d;
        unf_q  <= unf_d;
        bub_q  <= bub_d;
      end
    end
  end

  tdc_code_accum #(
    .CodeW    (CodeW),
    .NavgLog2 (NAVG_LOG2)
  ) u_accum (
    .clk          (clk),
    .rst          (rst),
    .code_valid_i (code_valid_q),
    .code_i       (code_q),
    .clr_i        (bus.acc_clr),
    .sum_o        (sum_out),
    .sum_valid_o  (sum_valid)
  );

  assign bus.code_out   = code_q;
  assign bus.code_valid = code_valid_q;
  assign bus.ovf        = ovf_q;
  assign bus.unf        = unf_q;
  assign bus.bubble_err = bub_q;
  assign bus.sum_out    = sum_out;
  assign bus.sum_valid  = sum_valid;

endmodule
